// File: rtl/insn_encoder_pkg.sv
// Shared instruction-format definitions: class encoding, field positions,
// opcode constants and the field-to-word packing helpers.
package insn_encoder_pkg;

    localparam int INSN_W = 9;

    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_BRANCH  = 2'd1,
        CLS_DATA    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } insn_class_e;

    // Field positions inside the 9-bit word
    localparam int DATA_FLAG_BIT   = 8;
    localparam int IMM_EN_BIT      = 7;
    localparam int BRANCH_FLAG_BIT = 6;

    // DATA operations (2-bit subop)
    localparam logic [1:0] kMOVE  = 2'd0;
    localparam logic [1:0] kFLAG  = 2'd1;
    localparam logic [1:0] kLOAD  = 2'd2;
    localparam logic [1:0] kSTORE = 2'd3;

    // ALU operations (3-bit subop)
    localparam logic [2:0] kALU_ADD = 3'd0;
    localparam logic [2:0] kALU_SUB = 3'd1;
    localparam logic [2:0] kALU_AND = 3'd2;
    localparam logic [2:0] kALU_OR  = 3'd3;
    localparam logic [2:0] kALU_XOR = 3'd4;
    localparam logic [2:0] kALU_SHL = 3'd5;
    localparam logic [2:0] kALU_SHR = 3'd6;
    localparam logic [2:0] kALU_CMP = 3'd7;

    // Class 3, or a DATA op using the reserved upper subop bit
    function automatic logic insn_illegal(input logic [1:0] cls, input logic [2:0] subop);
        return (cls == CLS_ILLEGAL) || ((cls == CLS_DATA) && subop[2]);
    endfunction

    function automatic logic [INSN_W-1:0] insn_pack(
        input insn_class_e cls,
        input logic [2:0]  subop,
        input logic [2:0]  dst,
        input logic [2:0]  src,
        input logic        imm_en,
        input logic [2:0]  imm,
        input logic [6:0]  br
    );
        logic [INSN_W-1:0] w;
        w = '0;
        case (cls)
            CLS_DATA: begin
                w[DATA_FLAG_BIT] = 1'b1;
                w[7:6]           = subop[1:0];
                w[5:3]           = dst;
                w[2:0]           = src;
            end
            CLS_ALU: begin
                w[IMM_EN_BIT]      = imm_en;
                w[BRANCH_FLAG_BIT] = 1'b0;
                w[5:3]             = subop;
                w[2:0]             = imm_en ? imm : 3'b000;
            end
            CLS_BRANCH: begin
                w[IMM_EN_BIT]      = br[6];
                w[BRANCH_FLAG_BIT] = 1'b1;
                w[5:0]             = br[5:0];
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/insn_encoder_fifo.sv
// Small synchronous FIFO holding packed words; read data is registered on pop.
module insn_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [W-1:0]  rdata_reg;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when indices match
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = rdata_reg;

    // Storage array write; no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[PW-1:0]] <= wdata;
        end
    end

    // Pointer update and registered head read
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rdata_reg  <= mem[rd_ptr_reg[PW-1:0]];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/insn_encoder.sv
// Instruction encoder: packs decoded field bundles into 9-bit words and
// writes them sequentially into instruction memory from a base address.
module insn_encoder
    import insn_encoder_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int LENW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [LENW-1:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [2:0]        in_subop,
    input  logic [2:0]        in_dst,
    input  logic [2:0]        in_src,
    input  logic              in_imm_en,
    input  logic [2:0]        in_imm,
    input  logic [6:0]        in_br,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [INSN_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     mem_addr_reg;
    logic              mem_we_reg;
    logic [LENW-1:0]   len_reg;
    logic [LENW-1:0]   acc_reg;
    logic [7:0]        err_cnt_reg;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              accept, bundle_bad;
    logic [INSN_W-1:0] packed_word;

    assign in_ready    = (state_reg == ST_LOAD) && !fifo_full && (acc_reg < len_reg);
    assign accept      = in_valid && in_ready;
    assign bundle_bad  = insn_illegal(in_class, in_subop);
    assign packed_word = insn_pack(insn_class_e'(in_class), in_subop, in_dst, in_src,
                                   in_imm_en, in_imm, in_br);
    // Illegal bundles consume a slot of the session but never reach memory
    assign fifo_push   = accept && !bundle_bad;
    assign fifo_pop    = !fifo_empty && mem_ready;

    assign busy     = (state_reg == ST_LOAD);
    assign done     = (state_reg == ST_DONE);
    assign mem_we   = mem_we_reg;
    assign mem_addr = mem_addr_reg;
    assign err_cnt  = err_cnt_reg;

    insn_fifo #(
        .DEPTH (DEPTH),
        .W     (INSN_W)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (fifo_push),
        .wdata (packed_word),
        .pop   (fifo_pop),
        .rdata (mem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Session sequencing: a load ends once every bundle is accepted and drained
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = (len == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD: if ((acc_reg == len_reg) && fifo_empty) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Session bookkeeping and the registered memory write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            mem_addr_reg <= '0;
            mem_we_reg   <= 1'b0;
            len_reg      <= '0;
            acc_reg      <= '0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= fifo_pop;
            if ((state_reg == ST_IDLE) && start) begin
                wr_ptr_reg  <= base_addr;
                len_reg     <= len;
                acc_reg     <= '0;
                err_cnt_reg <= '0;
            end else begin
                if (accept) begin
                    acc_reg <= acc_reg + 1'b1;
                    if (bundle_bad && (err_cnt_reg != 8'hFF)) begin
                        err_cnt_reg <= err_cnt_reg + 1'b1;
                    end
                end
                if (fifo_pop) begin
                    mem_addr_reg <= wr_ptr_reg;
                    wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                end
            end
        end
    end

endmodule
